// File: rtl/vector_element_sequencer_if.sv
// Handshake and beat bus between vector decode and the element sequencer.
// The master is the decode/lane side; the slave is the sequencer itself.
interface vector_element_sequencer_if #(
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned VLEN      = 128,
   parameter int unsigned VL_WIDTH  = 8
);
   localparam int unsigned EIR_W = $clog2(VLEN / 8);

   logic                 start;
   logic                 ready;
   logic [VL_WIDTH-1:0]  vl;
   logic [VL_WIDTH-1:0]  vstart;
   logic [1:0]           sew;
   logic                 stall;
   logic                 flush;
   logic                 issue_valid;
   logic [VL_WIDTH-1:0]  elem_idx;
   logic [NUM_LANES-1:0] lane_active;
   logic [2:0]           vreg_offset;
   logic [EIR_W-1:0]     elem_in_reg;
   logic                 first;
   logic                 last;
   logic                 busy;
   logic                 done;

   modport master (
      output start, vl, vstart, sew, stall, flush,
      input  ready, issue_valid, elem_idx, lane_active, vreg_offset, elem_in_reg,
             first, last, busy, done
   );

   modport slave (
      input  start, vl, vstart, sew, stall, flush,
      output ready, issue_valid, elem_idx, lane_active, vreg_offset, elem_in_reg,
             first, last, busy, done
   );
endinterface

// File: rtl/vector_element_sequencer.sv
// Steps one vector instruction from vstart to vl-1, NUM_LANES elements per beat.
// Optional VECTOR_SEQ_PERF_EN adds instruction and stall performance counters.
module vector_element_sequencer #(
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned VLEN      = 128,
   parameter int unsigned VL_WIDTH  = 8
) (
   input  logic                        CLK,
   input  logic                        nRST,
   vector_element_sequencer_if.slave   seq
`ifdef VECTOR_SEQ_PERF_EN
   ,
   output logic [31:0]                 perf_insn_cnt,
   output logic [31:0]                 perf_stall_cnt
`endif
);
   localparam int unsigned EIR_W = $clog2(VLEN / 8);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

   state_t              state_q;
   logic [VL_WIDTH-1:0] elem_idx_q;
   logic [VL_WIDTH-1:0] vl_q;
   logic [VL_WIDTH-1:0] vstart_q;
   logic [1:0]          sew_q;

   logic                run;
   logic [VL_WIDTH:0]   next_sum;
   logic                last_beat;
   logic [3:0]          shift_amt;

   assign run = (state_q == StRun);

   // One extra bit so the compare cannot wrap when vl == VLEN.
   assign next_sum  = {1'b0, elem_idx_q} + (VL_WIDTH + 1)'(NUM_LANES);
   assign last_beat = (next_sum >= {1'b0, vl_q});

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [VL_WIDTH:0] lane_sum;
      assign lane_sum            = {1'b0, elem_idx_q} + (VL_WIDTH + 1)'(i);
      assign seq.lane_active[i]  = run && (lane_sum < {1'b0, vl_q});
   end

   // log2(elements per register) = log2(VLEN/8) - sew.
   assign shift_amt       = 4'(EIR_W) - {2'b00, sew_q};
   assign seq.vreg_offset = 3'(elem_idx_q >> shift_amt);
   assign seq.elem_in_reg = EIR_W'(elem_idx_q & ~({VL_WIDTH{1'b1}} << shift_amt));

   assign seq.ready       = (state_q == StIdle);
   assign seq.busy        = (state_q != StIdle);
   assign seq.done        = (state_q == StDone);
   assign seq.issue_valid = run;
   assign seq.elem_idx    = elem_idx_q;
   assign seq.first       = run && (elem_idx_q == vstart_q);
   assign seq.last        = run && last_beat;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= StIdle;
         elem_idx_q <= '0;
         vl_q       <= '0;
         vstart_q   <= '0;
         sew_q      <= '0;
      end else if (seq.flush) begin
         state_q <= StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (seq.start) begin
                  vl_q       <= seq.vl;
                  vstart_q   <= seq.vstart;
                  sew_q      <= seq.sew;
                  elem_idx_q <= seq.vstart;
                  if (seq.sew == 2'd3 || seq.vstart >= seq.vl) begin
                     state_q <= StDone;
                  end else begin
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               if (!seq.stall) begin
                  if (last_beat) begin
                     state_q <= StDone;
                  end else begin
                     elem_idx_q <= next_sum[VL_WIDTH-1:0];
                  end
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef VECTOR_SEQ_PERF_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         perf_insn_cnt  <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (state_q == StDone) begin
            perf_insn_cnt <= perf_insn_cnt + 32'd1;
         end
         if (run && seq.stall) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_vector_element_sequencer.sv
// Scoreboard bench: the driver pushes beats computed from the sequencing rules,
// a negedge monitor pops and compares every consumed beat and done pulse.
module tb_vector_element_sequencer;
   localparam int unsigned NUM_LANES = 2;
   localparam int unsigned VLEN      = 128;
   localparam int unsigned VL_WIDTH  = 8;

   typedef struct {
      bit is_done;
      int elem;
      int mask;
      int vreg;
      int eir;
      bit first;
      bit last;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t q[$];
   int   checks;
   int   errors;
   int   cyc;
   int   done_cyc;
   int   run_cycles;

`ifdef VECTOR_SEQ_PERF_EN
   logic [31:0] perf_insn;
   logic [31:0] perf_stall;
`endif

   vector_element_sequencer_if #(
      .NUM_LANES(NUM_LANES), .VLEN(VLEN), .VL_WIDTH(VL_WIDTH)
   ) sif ();

   vector_element_sequencer #(
      .NUM_LANES(NUM_LANES), .VLEN(VLEN), .VL_WIDTH(VL_WIDTH)
   ) dut (
      .CLK (clk),
      .nRST(rst_n),
      .seq (sif)
`ifdef VECTOR_SEQ_PERF_EN
      ,
      .perf_insn_cnt (perf_insn),
      .perf_stall_cnt(perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s", nm);
   endtask

   // Reference: list every beat the instruction should produce, then the done pulse.
   task automatic push_model(input int vl, input int vs, input int sw, output int beats);
      exp_t e;
      int   epr;
      beats = 0;
      if (sw != 3 && vs < vl) begin
         epr = VLEN / (8 * (1 << sw));
         for (int x = vs; x < vl; x += NUM_LANES) begin
            e.is_done = 1'b0;
            e.elem    = x;
            e.mask    = 0;
            for (int i = 0; i < NUM_LANES; i++) if (x + i < vl) e.mask |= (1 << i);
            e.vreg    = (x / epr) % 8;
            e.eir     = x % epr;
            e.first   = (x == vs);
            e.last    = (x + NUM_LANES >= vl);
            q.push_back(e);
            beats++;
         end
      end
      e = '{is_done: 1'b1, elem: 0, mask: 0, vreg: 0, eir: 0, first: 1'b0, last: 1'b0};
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (sif.issue_valid) run_cycles++;
         if (sif.done) begin
            done_cyc = cyc;
            if (q.size() == 0) fail_now("done_unexpected");
            else begin
               e = q.pop_front();
               check("done_order", sif.done, e.is_done);
            end
         end
         if (sif.issue_valid && !sif.stall && !sif.flush) begin
            if (q.size() == 0) fail_now("beat_unexpected");
            else begin
               e = q.pop_front();
               if (e.is_done) fail_now("beat_instead_of_done");
               else begin
                  check("elem_idx", sif.elem_idx, e.elem);
                  check("lane_active", sif.lane_active, e.mask);
                  check("vreg_offset", sif.vreg_offset, e.vreg);
                  check("elem_in_reg", sif.elem_in_reg, e.eir);
                  check("first", sif.first, e.first);
                  check("last", sif.last, e.last);
               end
            end
         end
         if (sif.flush) q.delete();
      end
   end

   // Called at posedge+1; returns at posedge+1 of the first cycle the DUT is ready again.
   // smode: 0 no stall, 1 random stall, 2 stall held 3 cycles on beat 1.
   task automatic run_insn(input int vl, input int vs, input int sw, input int smode,
                           input int flush_at);
      int beats;
      int k;
      int start_cyc;
      bit flushed;
`ifdef VECTOR_SEQ_PERF_EN
      logic [31:0] insn0;
      logic [31:0] stall0;
`endif
      k = 0;
      while (!sif.ready && k < 300) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (!sif.ready) fail_now("ready_timeout");
`ifdef VECTOR_SEQ_PERF_EN
      insn0  = perf_insn;
      stall0 = perf_stall;
`endif
      push_model(vl, vs, sw, beats);
      sif.start  = 1'b1;
      sif.vl     = VL_WIDTH'(vl);
      sif.vstart = VL_WIDTH'(vs);
      sif.sew    = 2'(sw);
      start_cyc  = cyc;
      run_cycles = 0;
      done_cyc   = -1;
      flushed    = 1'b0;
      for (k = 1; k < 400; k++) begin
         @(posedge clk);
         #1;
         sif.start = 1'b0;
         if (flushed) begin
            check("flush_ready", sif.ready, 1);
            check("flush_no_issue", sif.issue_valid, 0);
         end
         if (sif.ready) begin
            sif.stall = 1'b0;
            sif.flush = 1'b0;
            break;
         end
         sif.flush = (k == flush_at);
         flushed   = sif.flush;
         case (smode)
            1:       sif.stall = ($urandom_range(0, 3) == 0);
            2:       sif.stall = (k >= 2 && k <= 4);
            default: sif.stall = 1'b0;
         endcase
      end
      if (k >= 400) fail_now("insn_timeout");
      if (smode == 0 && flush_at < 0) begin
         check("ready_latency", k, beats + 2);
         check("done_latency", done_cyc - start_cyc, beats + 1);
         check("run_cycles", run_cycles, beats);
      end
      if (smode == 2) begin
         check("run_cycles_stall", run_cycles, beats + 3);
`ifdef VECTOR_SEQ_PERF_EN
         check("perf_stall_delta", perf_stall - stall0, 3);
         check("perf_insn_delta", perf_insn - insn0, 1);
`endif
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int vl;
      int vs;
      int beats;
      checks     = 0;
      errors     = 0;
      cyc        = 0;
      done_cyc   = -1;
      run_cycles = 0;
      rst_n      = 1'b0;
      sif.start  = 1'b0;
      sif.vl     = '0;
      sif.vstart = '0;
      sif.sew    = '0;
      sif.stall  = 1'b0;
      sif.flush  = 1'b0;

      #12;
      check("rst_ready", sif.ready, 1);
      check("rst_busy", sif.busy, 0);
      check("rst_done", sif.done, 0);
      check("rst_issue_valid", sif.issue_valid, 0);
      check("rst_elem_idx", sif.elem_idx, 0);
      check("rst_lane_active", sif.lane_active, 0);
      check("rst_first", sif.first, 0);
      check("rst_last", sif.last, 0);
      check("rst_vreg_offset", sif.vreg_offset, 0);
      check("rst_elem_in_reg", sif.elem_in_reg, 0);
`ifdef VECTOR_SEQ_PERF_EN
      check("rst_perf_insn", perf_insn, 0);
      check("rst_perf_stall", perf_stall, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_insn(5, 0, 2, 0, -1);
      run_insn(20, 0, 0, 0, -1);
      run_insn(8, 3, 2, 0, -1);
      run_insn(0, 0, 2, 0, -1);
      run_insn(6, 0, 2, 2, -1);
      run_insn(10, 0, 2, 0, 2);
      run_insn(7, 1, 1, 0, -1);
      run_insn(4, 0, 3, 0, -1);
      run_insn(128, 0, 2, 0, -1);
      run_insn(128, 126, 0, 0, -1);
      run_insn(128, 127, 0, 0, -1);
      run_insn(3, 5, 0, 0, -1);

      for (int n = 0; n < 40; n++) begin
         vl = $urandom_range(0, VLEN);
         vs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, vl + 3) : $urandom_range(0, 4);
         run_insn(vl, vs, $urandom_range(0, 3), $urandom_range(0, 1),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : -1);
      end

      // Asynchronous reset in the middle of a long instruction.
      while (!sif.ready) begin
         @(posedge clk);
         #1;
      end
      push_model(40, 0, 2, beats);
      sif.start  = 1'b1;
      sif.vl     = VL_WIDTH'(40);
      sif.vstart = '0;
      sif.sew    = 2'd2;
      @(posedge clk);
      #1;
      sif.start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", sif.busy, 0);
      check("midrst_ready", sif.ready, 1);
      check("midrst_issue_valid", sif.issue_valid, 0);
      check("midrst_elem_idx", sif.elem_idx, 0);
      check("midrst_lane_active", sif.lane_active, 0);
`ifdef VECTOR_SEQ_PERF_EN
      check("midrst_perf_insn", perf_insn, 0);
`endif
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_insn(5, 0, 2, 0, -1);

      check("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
